vga_scan_timing: RTL and testbench
==================================

VGA_SCAN_TIMING -- requirements
Module: vga_scan_timing

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 1280: visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 48: horizontal front porch, in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 112: hsync width, in pixels.
REQ-004 The block SHALL have parameter H_BP, default 248: horizontal back porch; H_TOTAL = sum of the four horizontal parameters = 1688.
REQ-005 The block SHALL have parameter V_ACTIVE, default 1024: visible lines.
REQ-006 The block SHALL have parameters V_FP 1, V_SYNC 3 and V_BP 38: vertical porches and sync, in lines; V_TOTAL = 1066.
REQ-007 The block SHALL have parameter SYNC_POL, default 1: asserted level of hsync and vsync.
REQ-008 The block SHALL have parameter PIPE_DELAY, default 2, legal range 1..4: cycles from counter outputs to the VGA pins.
REQ-009 The block SHALL have port clock, input, 1 bit: pixel clock.
REQ-010 The block SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-011 The block SHALL have port layer_color, input, 25 bits: bit0 = valid, bits 24:1 = RGB888 (R in 24:17), from the sprite/bullet layer.
REQ-012 The block SHALL have port bg_color, input, 24 bits: RGB888 background color.
REQ-013 The block SHALL have port display_col, output, 12 bits: current column counter.
REQ-014 The block SHALL have port display_row, output, 11 bits: current row counter.
REQ-015 The block SHALL have port calc, output, 1 bit: vertical-blank window in which layers update their state.
REQ-016 The block SHALL have port active, output, 1 bit: current counter position is visible.
REQ-017 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse at frame origin.
REQ-018 The block SHALL have port frame_count, output, 8 bits: count of completed frames.
REQ-019 The block SHALL have ports hsync and vsync, outputs, 1 bit each: delayed sync signals.
REQ-020 The block SHALL have port blank_n, output, 1 bit: delayed active indication.
REQ-021 The block SHALL have ports vga_r, vga_g and vga_b, outputs, 8 bits each: pixel color.

Function
REQ-022 display_col SHALL increment by 1 every clock and wrap from H_TOTAL-1 to 0; it keeps counting through blanking.
REQ-023 display_row SHALL increment only in the cycle display_col wraps, and SHALL wrap from V_TOTAL-1 to 0 on the same edge that col wraps.
REQ-024 active SHALL be the combinational decode of the registered counters: (col < H_ACTIVE) && (row < V_ACTIVE).
REQ-025 calc SHALL be registered and updated on the same edge as the counters, equal to (new row >= V_ACTIVE); it rises at (V_ACTIVE, 0) and falls at (0, 0).
REQ-026 frame_start SHALL be 1 exactly in the cycle the counters read (0,0) as a result of a wrap, never after reset release.
REQ-027 frame_count SHALL increment on each wrap to (0,0), and SHALL wrap from 255 to 0.
REQ-028 Raw hsync SHALL be SYNC_POL while col is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], and ~SYNC_POL otherwise.
REQ-029 Raw vsync SHALL be SYNC_POL while row is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], and ~SYNC_POL otherwise; it is decoded per row, independent of col.
REQ-030 hsync, vsync and blank_n SHALL equal raw hsync, raw vsync and active delayed by exactly PIPE_DELAY clocks through a shift register.
REQ-031 layer_color and bg_color SHALL be treated as belonging to the counter position PIPE_DELAY-1 cycles earlier, and SHALL be captured into the RGB output register.
REQ-032 RGB capture SHALL select layer_color[24:1] if layer_color[0]=1, else bg_color.
REQ-033 The selected color SHALL be forced to 0 when the delayed active tap at depth PIPE_DELAY-1 is 0.
REQ-034 vga_r/g/b SHALL therefore change on the same edge as blank_n.
REQ-035 Counter arithmetic SHALL be unsigned; the parameters SHALL satisfy H_TOTAL <= 4096 and V_TOTAL <= 2048, with no overflow handling required beyond that.

Reset
REQ-036 While reset=1 at an edge, the block SHALL set display_col=0, display_row=0, calc=0, frame_start=0, frame_count=0 and vga_r/g/b=0.
REQ-037 While reset=1 at an edge, the block SHALL clear the delay lines to hsync=vsync=~SYNC_POL and blank_n=0.
REQ-038 On the first edge after reset is released, col SHALL become 1; delayed outputs show reset values until the pipeline fills.
REQ-039 Reset asserted mid-frame SHALL take effect on the next edge; the block SHALL emit no frame_start and SHALL not increment frame_count for the aborted frame.

Verification (small config: H 8/2/2/2 giving H_TOTAL=14, V 4/1/1/1 giving V_TOTAL=7, PIPE_DELAY=2, SYNC_POL=1)
REQ-040 A bench SHALL cover: release reset, run 98 clocks -> counters at (0,0), frame_start=1 once, frame_count=1, no frame_start at release.
REQ-041 A bench SHALL cover: monitor one line -> raw hsync high at col 10..11; hsync pin high 2 clocks later; blank_n high for 8 consecutive clocks per visible line.
REQ-042 A bench SHALL cover: monitor calc -> rises when row becomes 4 at col 0, stays high for 3x14=42 clocks, falls at (0,0); vsync high only for row 5, delayed by 2 clocks.
REQ-043 A bench SHALL cover: layer_color=25'h1FFFFFF when col=3 and row=1, else valid=0; bg_color=24'h102030 -> at the pins, one pixel FFFFFF, the other visible pixels 10/20/30, and blanking pixels 0.
REQ-044 A bench SHALL cover: reset pulsed at row 2, col 5 -> next edge reads (0,0) with calc=0, frame_count unchanged-reset to 0, hsync=0, blank_n=0 for 2 clocks after release.
REQ-045 A bench SHALL cover: run 256 frames -> frame_count wraps 255 to 0 with frame_start still pulsing.

Source files
------------

// File: rtl/vga_scan_timing.sv
// VGA raster timing: free-running column/row counters, sync/blank decode,
// a PIPE_DELAY-deep alignment pipeline to the pins, and pixel colour capture.
module vga_scan_timing #(
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned H_FP       = 48,
  parameter int unsigned H_SYNC     = 112,
  parameter int unsigned H_BP       = 248,
  parameter int unsigned V_ACTIVE   = 1024,
  parameter int unsigned V_FP       = 1,
  parameter int unsigned V_SYNC     = 3,
  parameter int unsigned V_BP       = 38,
  parameter bit          SYNC_POL   = 1'b1,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [24:0] layer_color,
  input  logic [23:0] bg_color,
  output logic [11:0] display_col,
  output logic [10:0] display_row,
  output logic        calc,
  output logic        active,
  output logic        frame_start,
  output logic [7:0]  frame_count,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [11:0] col_q, col_d;
  logic [10:0] row_q, row_d;
  logic        calc_q;
  logic        fs_q;
  logic [7:0]  fc_q;
  logic        line_end, frame_end;

  logic        active_c, hs_raw, vs_raw;

  // Chains hold the undelayed value at bit 0 and the pin value at bit PIPE_DELAY,
  // so the shift and the colour-mask tap work for any depth including 1.
  logic [PIPE_DELAY-1:0] hs_q, vs_q, act_q;
  logic [PIPE_DELAY:0]   hs_chain, vs_chain, act_chain;

  logic [23:0] rgb_q, rgb_d;

  // Next counter position and wrap detection.
  always_comb begin
    line_end  = (col_q == H_LAST);
    frame_end = line_end && (row_q == V_LAST);
    col_d     = line_end ? '0 : col_q + 12'd1;
    row_d     = row_q;
    if (line_end) begin
      row_d = (row_q == V_LAST) ? '0 : row_q + 11'd1;
    end
  end

  // Counters, vertical-blank window, frame pulse and frame counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      calc_q <= 1'b0;
      fs_q   <= 1'b0;
      fc_q   <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      calc_q <= (row_d >= V_ACT);
      fs_q   <= frame_end;
      if (frame_end) begin
        fc_q <= fc_q + 8'd1;
      end
    end
  end

  // Visible-area and raw sync decode of the current counter position.
  always_comb begin
    active_c = (col_q < H_ACT) && (row_q < V_ACT);
    hs_raw   = ((col_q >= HS_BEG) && (col_q <= HS_END)) ? SYNC_POL : ~SYNC_POL;
    vs_raw   = ((row_q >= VS_BEG) && (row_q <= VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  assign hs_chain  = {hs_q, hs_raw};
  assign vs_chain  = {vs_q, vs_raw};
  assign act_chain = {act_q, active_c};

  // Colour select, masked by the visibility of the pixel the inputs belong to.
  always_comb begin
    rgb_d = layer_color[0] ? layer_color[24:1] : bg_color;
    if (!act_chain[PIPE_DELAY-1]) begin
      rgb_d = '0;
    end
  end

  // Pin alignment pipeline and RGB output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      hs_q  <= {PIPE_DELAY{~SYNC_POL}};
      vs_q  <= {PIPE_DELAY{~SYNC_POL}};
      act_q <= '0;
      rgb_q <= '0;
    end else begin
      hs_q  <= hs_chain[PIPE_DELAY-1:0];
      vs_q  <= vs_chain[PIPE_DELAY-1:0];
      act_q <= act_chain[PIPE_DELAY-1:0];
      rgb_q <= rgb_d;
    end
  end

  assign display_col = col_q;
  assign display_row = row_q;
  assign calc        = calc_q;
  assign active      = active_c;
  assign frame_start = fs_q;
  assign frame_count = fc_q;
  assign hsync       = hs_chain[PIPE_DELAY];
  assign vsync       = vs_chain[PIPE_DELAY];
  assign blank_n     = act_chain[PIPE_DELAY];
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_scan_timing.sv
// Directed bench for vga_scan_timing on a 14x7 raster with a 2-clock pipeline.
module tb_vga_scan_timing;

  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FRAME = HT * VT;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [24:0] layer_color = '0;
  logic [23:0] bg_color = '0;
  logic [11:0] display_col;
  logic [10:0] display_row;
  logic        calc, active, frame_start, hsync, vsync, blank_n;
  logic [7:0]  frame_count, vga_r, vga_g, vga_b;

  int unsigned n_asserts = 0;
  int unsigned n_fail = 0;
  int t = 0;
  int fs_cnt, blank_cnt, white_cnt, calc_cnt;

  vga_scan_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1), .PIPE_DELAY(2)
  ) dut (
    .clock(clock), .reset(reset),
    .layer_color(layer_color), .bg_color(bg_color),
    .display_col(display_col), .display_row(display_row),
    .calc(calc), .active(active), .frame_start(frame_start),
    .frame_count(frame_count), .hsync(hsync), .vsync(vsync),
    .blank_n(blank_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clock = ~clock;

  function automatic int cc(int tt); return tt % HT; endfunction
  function automatic int rr(int tt); return (tt / HT) % VT; endfunction
  function automatic bit vis(int tt); return (cc(tt) < 8) && (rr(tt) < 4); endfunction
  function automatic bit special(int tt); return (cc(tt) == 3) && (rr(tt) == 1); endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // Layer pixel is valid only while the counters read (3,1); otherwise an
  // invalid (ignored) colour is presented over a fixed background.
  task automatic drive(input int tt);
    layer_color = special(tt) ? 25'h1FFFFFF : {24'hABCDEF, 1'b0};
    bg_color    = 24'h102030;
  endtask

  task automatic check_cycle(input int tt);
    logic [23:0] rgb;
    chk("col", 32'(display_col), 32'(cc(tt)));
    chk("row", 32'(display_row), 32'(rr(tt)));
    chk("active", 32'(active), 32'(vis(tt)));
    chk("calc", 32'(calc), 32'(rr(tt) >= 4));
    chk("frame_start", 32'(frame_start), 32'(tt > 0 && tt % FRAME == 0));
    chk("frame_count", 32'(frame_count), 32'((tt / FRAME) % 256));
    if (tt < 2) begin
      rgb = '0;
      chk("hsync", 32'(hsync), 32'(0));
      chk("vsync", 32'(vsync), 32'(0));
      chk("blank_n", 32'(blank_n), 32'(0));
    end else begin
      rgb = vis(tt - 2) ? (special(tt - 1) ? 24'hFFFFFF : 24'h102030) : 24'h0;
      chk("hsync", 32'(hsync), 32'(cc(tt - 2) == 10 || cc(tt - 2) == 11));
      chk("vsync", 32'(vsync), 32'(rr(tt - 2) == 5));
      chk("blank_n", 32'(blank_n), 32'(vis(tt - 2)));
    end
    chk("vga_r", 32'(vga_r), 32'(rgb[23:16]));
    chk("vga_g", 32'(vga_g), 32'(rgb[15:8]));
    chk("vga_b", 32'(vga_b), 32'(rgb[7:0]));
  endtask

  task automatic step;
    @(posedge clock);
    #1;
    t++;
    check_cycle(t);
    drive(t);
  endtask

  initial begin
    // Reset state held over several edges.
    drive(0);
    repeat (3) begin
      @(posedge clock);
      #1;
      check_cycle(0);
    end
    reset = 1'b0;

    // First frame: exactly one frame_start, at the wrap, none at release.
    fs_cnt = 0;
    repeat (FRAME) begin
      step();
      if (frame_start) fs_cnt++;
    end
    chk("fs_pulses", 32'(fs_cnt), 32'd1);
    chk("first_wrap_col", 32'(display_col), 32'd0);
    chk("first_wrap_fc", 32'(frame_count), 32'd1);

    // Second frame: per-frame totals at the pins and for calc.
    blank_cnt = 0; white_cnt = 0; calc_cnt = 0;
    repeat (FRAME) begin
      step();
      if (blank_n) blank_cnt++;
      if ({vga_r, vga_g, vga_b} == 24'hFFFFFF) white_cnt++;
      if (calc) calc_cnt++;
    end
    chk("blank_cnt", 32'(blank_cnt), 32'd32);
    chk("white_cnt", 32'(white_cnt), 32'd1);
    chk("calc_cnt", 32'(calc_cnt), 32'd42);

    // Mid-frame reset at (5,2) of the third frame.
    repeat (33) step();
    chk("pre_reset_col", 32'(display_col), 32'd5);
    chk("pre_reset_row", 32'(display_row), 32'd2);
    chk("pre_reset_fc", 32'(frame_count), 32'd2);
    reset = 1'b1;
    @(posedge clock);
    #1;
    t = 0;
    check_cycle(0);
    drive(0);
    reset = 1'b0;

    // 256 frames from reset: frame_count wraps 255 -> 0, frame_start still pulses.
    repeat (256 * FRAME - 1) step();
    chk("fc_255", 32'(frame_count), 32'd255);
    step();
    chk("fc_wrap", 32'(frame_count), 32'd0);
    chk("fs_at_wrap", 32'(frame_start), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
